vectrex_cart_loader: RTL
========================

Name: vectrex_cart_loader

Overview:
- Sequences the HPS ioctl download stream into the cartridge RAM through a write handshake.
- Computes the power-of-two cartridge address mask and flags bytes that fall outside the RAM.
- Owns the core reset: holds the Vectrex core in reset during a download, and for a fixed stretch after any reset request, before releasing it.
- Sits between hps_io and the vectrex core / cart RAM in the emu top level.

Parameters:
- ADDR_W, 15, cart RAM address width; the RAM holds 2^ADDR_W bytes.
- HOLD_CYCLES, 12000000, clk_sys cycles the core stays in reset after the last reset cause clears.

Ports:
- clk_sys  in  1  system clock; all logic is in this domain.
- reset  in  1  asynchronous, active-high reset.
- reset_req  in  1  level request for a core reset (status/button/RESET OR).
- ioctl_download  in  1  download in progress.
- ioctl_wr  in  1  single-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  stall request back to hps_io.
- ram_addr  out  ADDR_W  cart RAM write address.
- ram_din  out  8  cart RAM write data.
- ram_we  out  1  write request; held until ack.
- ram_ack  in  1  RAM accepted the write this cycle.
- cart_mask  out  ADDR_W  address mask for the loaded image.
- cart_valid  out  1  a completed image with at least 1 byte is present.
- cart_overflow  out  1  at least one byte was dropped in this download.
- core_reset  out  1  reset to the vectrex core.

Behaviour:
- States: HOLD, RUN, LOAD, WRITE.
- Async reset values:
  - State is HOLD with hold counter = 0.
  - core_reset=1, ram_we=0, ioctl_wait=0, cart_mask=0, cart_valid=0, cart_overflow=0.
  - ram_addr=0, ram_din=0, skid buffer empty.
- core_reset is a registered output: it is 1 in every state except RUN.
- Download start:
  - A rising edge of ioctl_download, detected against a registered copy, moves any state to LOAD.
  - On that edge: cart_mask<=0, cart_valid<=0, cart_overflow<=0.
- Byte acceptance, in LOAD on an ioctl_wr cycle:
  - If ioctl_addr >= 2^ADDR_W: drop the byte, set cart_overflow<=1, stay in LOAD.
  - Otherwise: ram_addr<=ioctl_addr[ADDR_W-1:0], ram_din<=ioctl_dout, ram_we<=1, ioctl_wait<=1, go to WRITE. ram_we is visible the cycle after the strobe.
- Mask update, applied per accepted byte, in the same cycle it is accepted:
  - If (addr & ~cart_mask) != 0 then cart_mask <= (cart_mask<<1)|1.
  - For sequential addresses from 0, this yields the smallest 2^k-1 that covers the highest address.
- WRITE:
  - ram_addr, ram_din and ram_we stay stable until the cycle in which ram_ack=1.
  - If the skid buffer is empty on the ack cycle: ram_we<=0, ioctl_wait<=0, return to LOAD.
  - If the skid buffer is full on the ack cycle: load its byte into the RAM outputs, ram_we stays 1, stay in WRITE.
  - A ram_ack seen outside WRITE is ignored.
- Skid buffer:
  - One entry. It captures an ioctl_wr that arrives while in WRITE, because ioctl_wait takes a cycle to act. The out-of-range rule and mask rule apply when the byte is captured.
  - An ioctl_wr that arrives while the skid buffer is full drops that byte and sets cart_overflow<=1.
- Download end:
  - On the falling edge of ioctl_download, the current write and any buffered write complete first.
  - Then go to HOLD with counter=0.
  - cart_valid<=1 on that transition if at least one byte was written to RAM, otherwise it stays 0.
- HOLD:
  - The counter increments each cycle while reset_req=0.
  - Any cycle with reset_req=1 clears the counter to 0.
  - When the counter reaches HOLD_CYCLES-1 with reset_req=0, go to RUN. core_reset becomes 0 on the first RUN cycle.
- RUN: reset_req=1 goes to HOLD with counter=0, and core_reset=1 on the next cycle.
- reset_req in LOAD or WRITE is ignored, since the core is already held in reset.
- Simultaneous events:
  - A download rising edge takes priority over reset_req.
  - ram_ack and a new ioctl_wr in the same cycle: the ack completes the current write and the new byte goes to the skid buffer.
- Async reset in the middle of a download abandons it: no RAM write completes, and cart_valid=0.

Test Plan:
- Power-up, HOLD_CYCLES=16, reset_req=0 -> core_reset=1 for 16 cycles after reset release, then 0; cart_valid=0.
- Download 4096 sequential bytes with ram_ack on the cycle after each ram_we -> 4096 RAM writes with correct addr/data; cart_mask=0x0FFF; cart_valid=1 after the falling edge; core_reset releases 16 cycles later.
- ram_ack delayed 5 cycles with back-to-back ioctl_wr -> second byte held in the skid buffer; ram_we continuous; no byte lost; third strobe while the skid buffer is full -> dropped, cart_overflow=1.
- ioctl_addr=0x8000 with ADDR_W=15 -> no ram_we, cart_overflow=1, cart_mask unchanged.
- reset_req pulses in RUN, then again after 10 HOLD cycles -> core_reset stays 1 until 16 cycles after the second pulse.
- Async reset asserted mid-download, then a new download of 1 byte at address 0 -> cart_mask=0x0000, cart_valid=1 after the falling edge.

Source files
------------

// File: rtl/vectrex_cart_loader.sv
// Vectrex cartridge loader: moves the hps_io download stream into cart RAM,
// tracks the image size mask, and owns the core reset.
module vectrex_cart_loader #(
   parameter int ADDR_W      = 15,
   parameter int HOLD_CYCLES = 12000000
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              reset_req,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   output logic              ioctl_wait,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_din,
   output logic              ram_we,
   input  logic              ram_ack,
   output logic [ADDR_W-1:0] cart_mask,
   output logic              cart_valid,
   output logic              cart_overflow,
   output logic              core_reset
);

   localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

   typedef enum logic [1:0] {S_HOLD, S_RUN, S_LOAD, S_WRITE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  hold_cnt;
   logic              dl_q;
   logic              wrote_any;
   logic              skid_full;
   logic [ADDR_W-1:0] skid_addr;
   logic [7:0]        skid_din;

   logic              dl_rise;
   logic              in_range;
   logic [ADDR_W-1:0] byte_addr;
   logic [ADDR_W-1:0] mask_next;

   assign dl_rise   = ioctl_download & ~dl_q;
   assign in_range  = (ioctl_addr >> ADDR_W) == 25'd0;
   assign byte_addr = ioctl_addr[ADDR_W-1:0];
   // Grow the mask by one bit whenever the byte lands outside the current power-of-two window.
   assign mask_next = |(byte_addr & ~cart_mask) ?
                      ((cart_mask << 1) | {{(ADDR_W-1){1'b0}}, 1'b1}) : cart_mask;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state         <= S_HOLD;
         hold_cnt      <= '0;
         dl_q          <= 1'b0;
         wrote_any     <= 1'b0;
         skid_full     <= 1'b0;
         skid_addr     <= '0;
         skid_din      <= '0;
         core_reset    <= 1'b1;
         ram_we        <= 1'b0;
         ioctl_wait    <= 1'b0;
         ram_addr      <= '0;
         ram_din       <= '0;
         cart_mask     <= '0;
         cart_valid    <= 1'b0;
         cart_overflow <= 1'b0;
      end else begin
         dl_q <= ioctl_download;
         if (dl_rise) begin
            state         <= S_LOAD;
            core_reset    <= 1'b1;
            cart_mask     <= '0;
            cart_valid    <= 1'b0;
            cart_overflow <= 1'b0;
            wrote_any     <= 1'b0;
            skid_full     <= 1'b0;
            ram_we        <= 1'b0;
            ioctl_wait    <= 1'b0;
         end else begin
            case (state)
               S_HOLD: begin
                  if (reset_req)
                     hold_cnt <= '0;
                  else if (hold_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                     state      <= S_RUN;
                     core_reset <= 1'b0;
                  end else
                     hold_cnt <= hold_cnt + 1'b1;
               end
               S_RUN: begin
                  if (reset_req) begin
                     state      <= S_HOLD;
                     hold_cnt   <= '0;
                     core_reset <= 1'b1;
                  end
               end
               S_LOAD: begin
                  if (!ioctl_download) begin
                     state    <= S_HOLD;
                     hold_cnt <= '0;
                     if (wrote_any) cart_valid <= 1'b1;
                  end else if (ioctl_wr) begin
                     if (!in_range)
                        cart_overflow <= 1'b1;
                     else begin
                        ram_addr   <= byte_addr;
                        ram_din    <= ioctl_dout;
                        ram_we     <= 1'b1;
                        ioctl_wait <= 1'b1;
                        cart_mask  <= mask_next;
                        state      <= S_WRITE;
                     end
                  end
               end
               S_WRITE: begin
                  if (ram_ack) begin
                     wrote_any <= 1'b1;
                     if (skid_full) begin
                        ram_addr  <= skid_addr;
                        ram_din   <= skid_din;
                        skid_full <= 1'b0;
                     end else if (ioctl_wr && in_range) begin
                        // Byte arriving on the ack cycle passes straight through the empty skid slot.
                        ram_addr <= byte_addr;
                        ram_din  <= ioctl_dout;
                     end else begin
                        ram_we     <= 1'b0;
                        ioctl_wait <= 1'b0;
                        state      <= S_LOAD;
                     end
                  end else if (ioctl_wr && in_range && !skid_full) begin
                     skid_addr <= byte_addr;
                     skid_din  <= ioctl_dout;
                     skid_full <= 1'b1;
                  end
                  if (ioctl_wr) begin
                     if (!in_range || skid_full)
                        cart_overflow <= 1'b1;
                     else
                        cart_mask <= mask_next;
                  end
               end
               default: state <= S_HOLD;
            endcase
         end
      end
   end

endmodule
